// File: rtl/wide_mult_result_serializer.sv
// Captures 256-bit signed results from a fixed-latency pipelined multiplier,
// queues them with an 8-bit sequence tag, and streams each result out as four
// 64-bit beats (least-significant word first) over a valid/ready handshake.
// DEPTH must be a power of two between 2 and 16 so that the pointers wrap
// naturally and fifo_count fits in 5 bits.
module wide_mult_result_serializer #(
  parameter int LATENCY = 7,
  parameter int DEPTH   = 8
) (
  input  logic         clock,
  input  logic         resetn,
  input  logic         start,
  input  logic [255:0] return_val,
  input  logic         clear,
  output logic [63:0]  out_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic         out_last,
  output logic [7:0]   out_tag,
  output logic [4:0]   fifo_count,
  output logic         overflow
);

  localparam int PW = $clog2(DEPTH);

  logic [LATENCY-1:0] tracker;
  logic [LATENCY-1:0] tracker_next;
  logic               capture;
  logic [263:0]       mem [DEPTH];
  logic [PW-1:0]      wr_ptr;
  logic [PW-1:0]      rd_ptr;
  logic [1:0]         beat;
  logic [7:0]         seq;
  logic [263:0]       head;
  logic [63:0]        word;
  logic               full;
  logic               pop;
  logic               wr_en;
  logic               drop;

  // Issue tracker: a start bit reaches the top stage LATENCY edges later,
  // which is the edge at which return_val carries that product.
  generate
    if (LATENCY > 1) begin : g_shift
      assign tracker_next = {tracker[LATENCY-2:0], start};
    end else begin : g_single
      assign tracker_next = start;
    end
  endgenerate

  assign capture = tracker[LATENCY-1];
  assign full    = (fifo_count == 5'(DEPTH));
  assign pop     = out_valid & out_ready & (beat == 2'd3);
  // A full FIFO can still accept a capture if the head leaves at the same edge.
  assign wr_en   = capture & (~full | pop);
  assign drop    = capture & full & ~pop;

  // Control state: tracker, pointers, beat, sequence, occupancy, overflow.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      tracker    <= '0;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      beat       <= 2'd0;
      seq        <= 8'd0;
      fifo_count <= 5'd0;
      overflow   <= 1'b0;
    end else if (clear) begin
      tracker    <= '0;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      beat       <= 2'd0;
      seq        <= 8'd0;
      fifo_count <= 5'd0;
      overflow   <= 1'b0;
    end else begin
      tracker <= tracker_next;
      if (capture) seq <= seq + 8'd1;
      if (wr_en) wr_ptr <= wr_ptr + 1'b1;
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      if (out_valid && out_ready) beat <= beat + 2'd1;
      if (wr_en && !pop) fifo_count <= fifo_count + 5'd1;
      else if (pop && !wr_en) fifo_count <= fifo_count - 5'd1;
      if (drop) overflow <= 1'b1;
    end
  end

  // Result storage: {result, tag} per entry; contents need no reset since
  // occupancy alone decides what is visible.
  always_ff @(posedge clock) begin
    if (wr_en && !clear) mem[wr_ptr] <= {return_val, seq};
  end

  assign head = mem[rd_ptr];

  // Select the 64-bit word of the head entry addressed by the beat counter.
  always_comb begin
    word = 64'd0;
    case (beat)
      2'd0: word = head[71:8];
      2'd1: word = head[135:72];
      2'd2: word = head[199:136];
      2'd3: word = head[263:200];
      default: word = 64'd0;
    endcase
  end

  assign out_valid = (fifo_count != 5'd0);
  assign out_data  = out_valid ? word : 64'd0;
  assign out_last  = out_valid & (beat == 2'd3);
  assign out_tag   = out_valid ? head[7:0] : 8'd0;

endmodule

// File: tb/tb_wide_mult_result_serializer.sv
// Directed bench for wide_mult_result_serializer (LATENCY=7, DEPTH=8).
module tb_wide_mult_result_serializer;

  logic         clock;
  logic         resetn;
  logic         start;
  logic [255:0] return_val;
  logic         clear;
  logic [63:0]  out_data;
  logic         out_valid;
  logic         out_ready;
  logic         out_last;
  logic [7:0]   out_tag;
  logic [4:0]   fifo_count;
  logic         overflow;

  int checks = 0;
  int errors = 0;

  logic [63:0] bd_q[$];
  logic [7:0]  bt_q[$];
  logic        bl_q[$];
  int          exp_tags[$];
  logic [7:0]  wrap_q[$];
  logic        saw_valid;
  logic [255:0] ref_val;

  wide_mult_result_serializer #(.LATENCY(7), .DEPTH(8)) dut (
    .clock(clock), .resetn(resetn), .start(start), .return_val(return_val),
    .clear(clear), .out_data(out_data), .out_valid(out_valid),
    .out_ready(out_ready), .out_last(out_last), .out_tag(out_tag),
    .fifo_count(fifo_count), .overflow(overflow)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [255:0] pat(input int i);
    logic [255:0] r;
    for (int j = 0; j < 4; j++) r[64*j +: 64] = {32'(i), 32'(j * 16 + i * 3 + 1)};
    return r;
  endfunction

  task automatic chk_idle(input string tag);
    chk({tag, "_valid"}, 256'(out_valid), 256'd0);
    chk({tag, "_data"}, 256'(out_data), 256'd0);
    chk({tag, "_last"}, 256'(out_last), 256'd0);
    chk({tag, "_tag"}, 256'(out_tag), 256'd0);
    chk({tag, "_count"}, 256'(fifo_count), 256'd0);
    chk({tag, "_ovf"}, 256'(overflow), 256'd0);
  endtask

  initial begin
    resetn = 1'b0; start = 1'b0; return_val = '0; clear = 1'b0; out_ready = 1'b0;
    repeat (2) tick();
    chk_idle("reset");
    resetn = 1'b1;
    tick();

    // Single result: words {4,3,2,1}, tag 0.
    return_val = {64'd4, 64'd3, 64'd2, 64'd1};
    out_ready = 1'b1;
    start = 1'b1; tick(); start = 1'b0;
    repeat (6) tick();
    chk("single_early_valid", 256'(out_valid), 256'd0);
    tick();
    chk("single_b0_valid", 256'(out_valid), 256'd1);
    chk("single_b0_data", 256'(out_data), 256'd1);
    chk("single_b0_tag", 256'(out_tag), 256'd0);
    chk("single_b0_last", 256'(out_last), 256'd0);
    chk("single_count", 256'(fifo_count), 256'd1);
    tick(); chk("single_b1_data", 256'(out_data), 256'd2);
    tick(); chk("single_b2_data", 256'(out_data), 256'd3);
    tick(); chk("single_b3_data", 256'(out_data), 256'd4);
    chk("single_b3_last", 256'(out_last), 256'd1);
    tick();
    chk("single_done_valid", 256'(out_valid), 256'd0);
    chk("single_done_count", 256'(fifo_count), 256'd0);
    chk("single_done_data", 256'(out_data), 256'd0);

    // Backpressure at beat 2: words {40,30,20,10}, tag 1.
    return_val = {64'd40, 64'd30, 64'd20, 64'd10};
    start = 1'b1; tick(); start = 1'b0;
    repeat (7) tick();
    chk("bp_b0_data", 256'(out_data), 256'd10);
    chk("bp_b0_tag", 256'(out_tag), 256'd1);
    tick(); chk("bp_b1_data", 256'(out_data), 256'd20);
    tick(); chk("bp_b2_data", 256'(out_data), 256'd30);
    out_ready = 1'b0;
    for (int k = 0; k < 5; k++) begin
      tick();
      chk("bp_hold_data", 256'(out_data), 256'd30);
      chk("bp_hold_last", 256'(out_last), 256'd0);
      chk("bp_hold_tag", 256'(out_tag), 256'd1);
    end
    out_ready = 1'b1;
    tick();
    chk("bp_b3_data", 256'(out_data), 256'd40);
    chk("bp_b3_last", 256'(out_last), 256'd1);
    tick();
    chk("bp_done_count", 256'(fifo_count), 256'd0);

    // Full FIFO with a pop on the same edge as a capture: tags 2..10.
    for (int i = 0; i < 16; i++) begin
      start = (i < 9);
      out_ready = (i >= 12);
      return_val = pat(100 + i);
      tick();
      if (i == 14) chk("fp_count_full", 256'(fifo_count), 256'd8);
    end
    start = 1'b0;
    chk("fp_count_after", 256'(fifo_count), 256'd8);
    chk("fp_ovf", 256'(overflow), 256'd0);
    chk("fp_head_tag", 256'(out_tag), 256'd3);
    repeat (31) tick();
    chk("fp_tail_tag", 256'(out_tag), 256'd10);
    chk("fp_tail_last", 256'(out_last), 256'd1);
    tick();
    chk("fp_drained", 256'(fifo_count), 256'd0);

    // Flush sequence number before the burst so tags start at 0.
    clear = 1'b1; tick(); clear = 1'b0;

    // Burst of 47 back-to-back starts with out_ready=1.
    for (int t = 0; t < 10; t++) exp_tags.push_back(t);
    for (int t = 12; t <= 44; t += 4) exp_tags.push_back(t);
    out_ready = 1'b1;
    for (int i = 0; i < 110; i++) begin
      start = (i < 47);
      return_val = pat(i);
      tick();
      if (i == 16) chk("burst_ovf_before", 256'(overflow), 256'd0);
      if (i == 17) chk("burst_ovf_tag10", 256'(overflow), 256'd1);
      if (out_valid) begin
        bd_q.push_back(out_data);
        bt_q.push_back(out_tag);
        bl_q.push_back(out_last);
      end
    end
    start = 1'b0;
    chk("burst_beats", 256'(bd_q.size()), 256'(exp_tags.size() * 4));
    for (int b = 0; b < bd_q.size() && b < exp_tags.size() * 4; b++) begin
      ref_val = pat(exp_tags[b / 4] + 7);
      chk("burst_tag", 256'(bt_q[b]), 256'(exp_tags[b / 4]));
      chk("burst_last", 256'(bl_q[b]), 256'((b % 4) == 3));
      chk("burst_data", 256'(bd_q[b]), 256'(ref_val[64 * (b % 4) +: 64]));
    end
    chk("burst_ovf_sticky", 256'(overflow), 256'd1);
    chk("burst_count_end", 256'(fifo_count), 256'd0);

    // Clear with 3 stored results and 4 starts in flight.
    out_ready = 1'b0;
    for (int i = 0; i < 10; i++) begin
      start = (i < 7);
      return_val = pat(200 + i);
      tick();
    end
    start = 1'b0;
    chk("clr_count_pre", 256'(fifo_count), 256'd3);
    clear = 1'b1; tick(); clear = 1'b0;
    chk_idle("clr");
    out_ready = 1'b1;
    saw_valid = 1'b0;
    repeat (10) begin tick(); saw_valid = saw_valid | out_valid; end
    chk("clr_no_beats", 256'(saw_valid), 256'd0);
    start = 1'b1; tick(); start = 1'b0;
    repeat (7) tick();
    chk("clr_next_valid", 256'(out_valid), 256'd1);
    chk("clr_next_tag", 256'(out_tag), 256'd0);
    repeat (4) tick();
    chk("clr_next_drained", 256'(fifo_count), 256'd0);

    // Reset with 3 stored results and 4 starts in flight.
    out_ready = 1'b0;
    for (int i = 0; i < 10; i++) begin
      start = (i < 7);
      return_val = pat(300 + i);
      tick();
    end
    start = 1'b0;
    chk("rst_count_pre", 256'(fifo_count), 256'd3);
    resetn = 1'b0; #1;
    chk_idle("rst_async");
    tick();
    resetn = 1'b1;
    out_ready = 1'b1;
    saw_valid = 1'b0;
    repeat (10) begin tick(); saw_valid = saw_valid | out_valid; end
    chk("rst_no_beats", 256'(saw_valid), 256'd0);
    start = 1'b1; tick(); start = 1'b0;
    repeat (7) tick();
    chk("rst_next_valid", 256'(out_valid), 256'd1);
    chk("rst_next_tag", 256'(out_tag), 256'd0);
    repeat (4) tick();

    // Tag wrap: 257 spaced results.
    clear = 1'b1; tick(); clear = 1'b0;
    for (int i = 0; i < 257 * 5 + 15; i++) begin
      start = ((i % 5) == 0) && (i < 257 * 5);
      return_val = pat(i);
      tick();
      if (out_valid && out_last) wrap_q.push_back(out_tag);
    end
    start = 1'b0;
    chk("wrap_results", 256'(wrap_q.size()), 256'd257);
    for (int k = 0; k < wrap_q.size() && k < 257; k++)
      chk("wrap_tag", 256'(wrap_q[k]), 256'(k % 256));
    chk("wrap_ovf", 256'(overflow), 256'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
